// File: rtl/axi4_lite_req_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one AXI4-Lite
// master user port, with one transaction in flight at a time.
module axi4_lite_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    input  logic [NUM_REQ*STRB_WIDTH-1:0]    req_wstrb,
    output logic [NUM_REQ-1:0]               req_grant,
    output logic [NUM_REQ-1:0]               req_done,
    output logic [1:0]                       req_resp,
    output logic [DATA_WIDTH-1:0]            req_rdata,
    output logic                             busy,
    output logic                             write_req,
    output logic [ADDR_WIDTH-1:0]            write_addr,
    output logic [DATA_WIDTH-1:0]            write_data,
    output logic [STRB_WIDTH-1:0]            write_strb,
    input  logic                             write_done,
    input  logic [1:0]                       write_resp,
    output logic                             read_req,
    output logic [ADDR_WIDTH-1:0]            read_addr,
    input  logic [DATA_WIDTH-1:0]            read_data,
    input  logic                             read_done,
    input  logic [1:0]                       read_resp
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        lastGrant_q;
    logic [IDX_W-1:0]        owner_q;
    logic                    isWrite_q;
    logic [7:0]              timer_q;
    logic [NUM_REQ-1:0]      grant_q;
    logic [NUM_REQ-1:0]      doneVec_q;
    logic [1:0]              resp_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    busy_q;
    logic                    writeReq_q;
    logic                    readReq_q;
    logic [ADDR_WIDTH-1:0]   writeAddr_q;
    logic [DATA_WIDTH-1:0]   writeData_q;
    logic [STRB_WIDTH-1:0]   writeStrb_q;
    logic [ADDR_WIDTH-1:0]   readAddr_q;

    logic                    pickValid_d;
    logic [IDX_W-1:0]        nextOwner_d;
    logic [IDX_W-1:0]        candidate;
    logic [ADDR_WIDTH-1:0]   selAddr;
    logic [DATA_WIDTH-1:0]   selData;
    logic [STRB_WIDTH-1:0]   selStrb;
    logic                    selWrite;
    logic                    matchDone;

    // Round-robin pick: first valid requester after the previous owner.
    always_comb begin
        pickValid_d = 1'b0;
        nextOwner_d = '0;
        candidate   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            candidate = IDX_W'((int'(lastGrant_q) + off) % NUM_REQ);
            if (!pickValid_d && req_valid[candidate]) begin
                pickValid_d = 1'b1;
                nextOwner_d = candidate;
            end
        end
    end

    assign selAddr   = req_addr[int'(nextOwner_d)*ADDR_WIDTH +: ADDR_WIDTH];
    assign selData   = req_wdata[int'(nextOwner_d)*DATA_WIDTH +: DATA_WIDTH];
    assign selStrb   = req_wstrb[int'(nextOwner_d)*STRB_WIDTH +: STRB_WIDTH];
    assign selWrite  = req_write[nextOwner_d];
    assign matchDone = isWrite_q ? write_done : read_done;

    // Transaction FSM; every output is a register loaded on state transitions.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lastGrant_q <= IDX_W'(NUM_REQ - 1);
            owner_q     <= '0;
            isWrite_q   <= 1'b0;
            timer_q     <= '0;
            grant_q     <= '0;
            doneVec_q   <= '0;
            resp_q      <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            writeReq_q  <= 1'b0;
            readReq_q   <= 1'b0;
            writeAddr_q <= '0;
            writeData_q <= '0;
            writeStrb_q <= '0;
            readAddr_q  <= '0;
        end else begin
            writeReq_q <= 1'b0;
            readReq_q  <= 1'b0;
            doneVec_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (pickValid_d) begin
                        owner_q     <= nextOwner_d;
                        isWrite_q   <= selWrite;
                        grant_q     <= NUM_REQ'(1) << nextOwner_d;
                        busy_q      <= 1'b1;
                        writeAddr_q <= selAddr;
                        writeData_q <= selData;
                        writeStrb_q <= selStrb;
                        readAddr_q  <= selAddr;
                        writeReq_q  <= selWrite;
                        readReq_q   <= !selWrite;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer_q <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (matchDone || (timer_q == 8'(TIMEOUT - 1))) begin
                        if (matchDone) begin
                            resp_q  <= isWrite_q ? write_resp : read_resp;
                            rdata_q <= isWrite_q ? '0 : read_data;
                        end else begin
                            resp_q  <= 2'b10;
                            rdata_q <= '0;
                        end
                        doneVec_q   <= grant_q;
                        writeAddr_q <= '0;
                        writeData_q <= '0;
                        writeStrb_q <= '0;
                        readAddr_q  <= '0;
                        timer_q     <= '0;
                        state_q     <= RESP;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                RESP: begin
                    lastGrant_q <= owner_q;
                    grant_q     <= '0;
                    busy_q      <= 1'b0;
                    resp_q      <= '0;
                    rdata_q     <= '0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_grant  = grant_q;
    assign req_done   = doneVec_q;
    assign req_resp   = resp_q;
    assign req_rdata  = rdata_q;
    assign busy       = busy_q;
    assign write_req  = writeReq_q;
    assign write_addr = writeAddr_q;
    assign write_data = writeData_q;
    assign write_strb = writeStrb_q;
    assign read_req   = readReq_q;
    assign read_addr  = readAddr_q;

endmodule

// File: doc/axi4_lite_req_arbiter.md
AXI4_LITE_REQ_ARBITER -- requirements
Module: axi4_lite_req_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- NUM_REQ, 4: number of requesters (2..8)
- ADDR_WIDTH, 32: address width
- DATA_WIDTH, 32: data width
- STRB_WIDTH, DATA_WIDTH/8: write strobe width
- TIMEOUT, 255: max cycles waiting for done (1..255)

REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request
- req_write  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- req_wstrb  in  NUM_REQ*STRB_WIDTH  packed strobes
- req_grant  out  NUM_REQ  one-hot owner of the current transaction
- req_done  out  NUM_REQ  one-cycle completion pulse to owner
- req_resp  out  2  response, valid with req_done
- req_rdata  out  DATA_WIDTH  read data, valid with req_done
- busy  out  1  transaction in progress
- write_req  out  1  pulse to master user port
- write_addr  out  ADDR_WIDTH  write address to master
- write_data  out  DATA_WIDTH  write data to master
- write_strb  out  STRB_WIDTH  write strobe to master
- write_done  in  1  master write-complete pulse
- write_resp  in  2  master BRESP
- read_req  out  1  pulse to master user port
- read_addr  out  ADDR_WIDTH  read address to master
- read_data  in  DATA_WIDTH  master read data
- read_done  in  1  master read-complete pulse
- read_resp  in  2  master RRESP

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.

REQ-004 IDLE with any req_valid high SHALL grant the first valid requester searching from last_grant+1 modulo NUM_REQ. On the grant it SHALL latch that requester's write, addr, wdata and wstrb, set req_grant and busy, and go to ISSUE.

REQ-005 ISSUE SHALL assert write_req or read_req, per the latched type, for exactly one cycle, then go to WAIT.

REQ-006 write_addr, write_data, write_strb and read_addr SHALL be driven from the latched values. They SHALL stay stable from ISSUE until leaving WAIT, and SHALL be 0 otherwise.

REQ-007 WAIT SHALL react only to the done of the matching type. It SHALL capture write_resp, or read_resp plus read_data, then go to RESP. The done of the other type SHALL be ignored.

REQ-008 A WAIT timeout counter SHALL start at 0 on entry to WAIT. If it reaches TIMEOUT without a matching done, the FSM SHALL go to RESP with resp=2'b10 and rdata=0.

REQ-009 RESP SHALL:
- pulse req_done[owner] for one cycle, with req_resp and req_rdata valid (rdata=0 for writes)
- update last_grant to the owner
- clear req_grant and busy
- go to IDLE

req_resp and req_rdata SHALL be 0 outside RESP.

REQ-010 Latency SHALL be: grant edge at cycle 0, write_req/read_req high in cycle 1, and req_done high the cycle after the done pulse is sampled. At most one transaction SHALL be outstanding.

REQ-011 Deasserting req_valid after grant SHALL NOT abort the transaction. Requests arriving while busy SHALL wait, and the next grant SHALL come from IDLE only (one idle cycle minimum between transactions).

REQ-012 A done pulse in IDLE, ISSUE or RESP SHALL be ignored.

REQ-013 Round-robin SHALL guarantee each continuously-valid requester a grant within NUM_REQ transactions.

Reset
REQ-014 With reset high at a clock edge, the block SHALL:
- enter IDLE
- drive all outputs to 0
- clear the timeout counter
- set last_grant=NUM_REQ-1, so requester 0 has first priority

REQ-015 Reset mid-transaction SHALL abandon the transaction with no req_done. A later stray done SHALL be ignored per REQ-012.

Verification
REQ-016 Single write: req_valid=4'b0010, write, addr=0x10, wdata=0xA5A5A5A5, wstrb=4'hF; master write_done 3 cycles later with resp 0 -> write_req one pulse with those values; req_done=4'b0010 one cycle; req_resp=0.

REQ-017 Single read: requester 3 reads 0x20; read_done with data 0xDEADBEEF, resp 0 -> req_done[3] pulse, req_rdata=0xDEADBEEF.

REQ-018 All four requesters valid continuously from reset -> grant order 0,1,2,3,0; exactly one req_done per transaction.

REQ-019 Timeout: TIMEOUT=8, no done after read_req -> req_done 9 cycles after read_req, req_resp=2'b10, req_rdata=0.

REQ-020 Reset asserted in WAIT, then write_done pulse after reset -> no req_done, outputs 0, next grant goes to requester 0.

REQ-021 Write in WAIT with a read_done pulse -> ignored; completion only on write_done.
